// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the ALU issue controller.
//   OP_*    : two-bit ALU opcodes passed through unchanged to the ALU.
//   state_e : issue FSM state encoding (IDLE/READ/EXEC/RESP, 2 bits).
package alu_issue_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    EXEC = 2'b10,
    RESP = 2'b11
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x WIDTH register file for the ALU issue controller.
//   clk_i              : clock, all writes on the rising edge
//   rst_ni             : synchronous active-low reset, clears every entry
//   ra_a_i / rd_a_o    : asynchronous read port A (first source)
//   ra_b_i / rd_b_o    : asynchronous read port B (second source)
//   wb_en_i/addr/data  : ALU writeback port
//   ld_en_i/addr/data  : preload port
// Writeback and load may both fire on one edge; on the same index the
// writeback wins, on different indices both are stored. Reset overrides both.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREG  = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AW-1:0]    ra_a_i,
  output logic [WIDTH-1:0] rd_a_o,
  input  logic [AW-1:0]    ra_b_i,
  output logic [WIDTH-1:0] rd_b_o,
  input  logic             wb_en_i,
  input  logic [AW-1:0]    wb_addr_i,
  input  logic [WIDTH-1:0] wb_data_i,
  input  logic             ld_en_i,
  input  logic [AW-1:0]    ld_addr_i,
  input  logic [WIDTH-1:0] ld_data_i
);

  logic [WIDTH-1:0] mem_q [NREG];

  // Per-entry write select so that two distinct indices can be written
  // on the same edge while a collision resolves to the writeback.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (wb_en_i && (wb_addr_i == AW'(i))) begin
          mem_q[i] <= wb_data_i;
        end else if (ld_en_i && (ld_addr_i == AW'(i))) begin
          mem_q[i] <= ld_data_i;
        end
      end
    end
  end

  // Reads see the pre-edge contents, so a same-edge write is not visible.
  assign rd_a_o = mem_q[ra_a_i];
  assign rd_b_o = mem_q[ra_b_i];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: multi-cycle issue controller acting as initiator of an external
// combinational ALU. Accepts rd <= rs op rt commands, reads operands from a
// local register file, drives the ALU, writes the result back and returns
// it on a response handshake.
//   Clk, Clrn                     : clock, synchronous active-low reset
//   cmd_valid/cmd_ready           : command handshake
//   cmd_op, cmd_rd, cmd_rs, cmd_rt: opcode and register indices
//   ld_en, ld_addr, ld_data       : register-file preload port (any state)
//   Alu_X, Alu_Y, Alu_Aluc        : registered ALU operands and opcode
//   Alu_R, Alu_Z                  : ALU result and zero flag
//   rsp_valid/rsp_ready           : response handshake
//   rsp_data, rsp_zero            : captured result and zero flag
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREG  = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_rs,
  input  logic [AW-1:0]    cmd_rt,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] Alu_X,
  output logic [WIDTH-1:0] Alu_Y,
  output logic [1:0]       Alu_Aluc,
  input  logic [WIDTH-1:0] Alu_R,
  input  logic             Alu_Z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rs_q;
  logic [AW-1:0]    rt_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       aluc_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;

  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             wb_en;

  assign wb_en = (state_q == EXEC);

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_rf (
    .clk_i     (Clk),
    .rst_ni    (Clrn),
    .ra_a_i    (rs_q),
    .rd_a_o    (rs_val),
    .ra_b_i    (rt_q),
    .rd_b_o    (rt_val),
    .wb_en_i   (wb_en),
    .wb_addr_i (rd_q),
    .wb_data_i (Alu_R),
    .ld_en_i   (ld_en),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data)
  );

  // cmd_ready and rsp_valid are registered flags that track the next state,
  // so cmd_ready stays low on the first IDLE cycle after a reset edge.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      aluc_q      <= OP_ADD;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_op;
            rd_q        <= cmd_rd;
            rs_q        <= cmd_rs;
            rt_q        <= cmd_rt;
            cmd_ready_q <= 1'b0;
            state_q     <= READ;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        READ: begin
          x_q     <= rs_val;
          y_q     <= rt_val;
          aluc_q  <= op_q;
          state_q <= EXEC;
        end
        EXEC: begin
          rsp_data_q  <= Alu_R;
          rsp_zero_q  <= Alu_Z;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          cmd_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign Alu_X     = x_q;
  assign Alu_Y     = y_q;
  assign Alu_Aluc  = aluc_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        Clk;
  logic        Clrn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_rs;
  logic [2:0]  cmd_rt;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] Alu_X;
  logic [31:0] Alu_Y;
  logic [1:0]  Alu_Aluc;
  logic [31:0] Alu_R;
  logic        Alu_Z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;

  typedef struct {
    logic [31:0] d;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_issue #(
    .WIDTH (32),
    .NREG  (8)
  ) dut (
    .Clk       (Clk),
    .Clrn      (Clrn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .Alu_X     (Alu_X),
    .Alu_Y     (Alu_Y),
    .Alu_Aluc  (Alu_Aluc),
    .Alu_R     (Alu_R),
    .Alu_Z     (Alu_Z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero)
  );

  // Behavioural ALU
  always_comb begin
    Alu_R = '0;
    case (Alu_Aluc)
      2'b00:   Alu_R = Alu_X + Alu_Y;
      2'b01:   Alu_R = Alu_X - Alu_Y;
      2'b10:   Alu_R = Alu_X & Alu_Y;
      default: Alu_R = Alu_X | Alu_Y;
    endcase
  end
  assign Alu_Z = (Alu_R == 32'd0);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted response.
  always @(negedge Clk) begin
    if (Clrn === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.d);
        check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.z});
      end
    end
  end

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    @(posedge Clk); #1;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge Clk); #1;
    ld_en = 1'b0;
  endtask

  // Returns one #1 after the accepting edge (i.e. inside the READ cycle).
  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [31:0] ed, input logic ez,
                       input bit push);
    int n;
    exp_t e;
    @(posedge Clk); #1;
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (cmd_ready !== 1'b1 && n < 50);
    if (cmd_ready !== 1'b1) begin
      check("issue_timeout", 32'd1, 32'd0);
      cmd_valid = 1'b0;
      return;
    end
    if (push) begin
      e.d = ed; e.z = ez;
      exp_q.push_back(e);
    end
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Follows a just-accepted command through READ, EXEC and into RESP.
  task automatic track(input logic [1:0] aluc, input logic [31:0] x, input logic [31:0] y);
    @(negedge Clk);
    check("read_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("read_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge Clk);
    check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("exec_aluc", {30'd0, Alu_Aluc}, {30'd0, aluc});
    check("exec_x", Alu_X, x);
    check("exec_y", Alu_Y, y);
    @(negedge Clk);
    check("resp_latency", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic readback(input logic [2:0] r, input logic [31:0] ed, input logic ez);
    issue(OP_OR, r, r, r, ed, ez, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Clrn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rsp_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_alu_x", Alu_X, 32'd0);
    check("rst_alu_y", Alu_Y, 32'd0);
    check("rst_aluc", {30'd0, Alu_Aluc}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    @(posedge Clk); #1;
    Clrn = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Basic add: 5 + 7 = 12
    load(3'd1, 32'd5);
    load(3'd2, 32'd7);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 32'd12, 1'b0, 1'b1);
    track(OP_ADD, 32'd5, 32'd7);
    readback(3'd3, 32'd12, 1'b0);

    // Subtract to zero, rs == rt
    load(3'd1, 32'h0000_1234);
    issue(OP_SUB, 3'd4, 3'd1, 3'd1, 32'd0, 1'b1, 1'b1);
    track(OP_SUB, 32'h0000_1234, 32'h0000_1234);
    readback(3'd4, 32'd0, 1'b1);

    // Logic ops
    load(3'd1, 32'hF0F0_F0F0);
    load(3'd2, 32'h0FF0_0FF0);
    issue(OP_AND, 3'd5, 3'd1, 3'd2, 32'h00F0_00F0, 1'b0, 1'b1);
    track(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    issue(OP_OR, 3'd6, 3'd1, 3'd2, 32'hFFF0_FFF0, 1'b0, 1'b1);
    track(OP_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);

    // Backpressure: F0F0F0F0 + 0FF00FF0 = 00E100E0 (carry out dropped)
    @(posedge Clk); #1;
    rsp_ready = 1'b0;
    issue(OP_ADD, 3'd7, 3'd1, 3'd2, 32'h00E1_00E0, 1'b0, 1'b1);
    @(posedge Clk); #1;
    cmd_op = OP_SUB; cmd_rd = 3'd2; cmd_rs = 3'd1; cmd_rt = 3'd2; cmd_valid = 1'b1;
    @(posedge Clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data", rsp_data, 32'h00E1_00E0);
      check("bp_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    end
    @(posedge Clk); #1;
    rsp_ready = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (cmd_ready !== 1'b1 && n < 10);
    check("bp_accept_delay", n, 32'd2);
    begin
      exp_t e;
      e.d = 32'hE100_E100; e.z = 1'b0;   // F0F0F0F0 - 0FF00FF0
      exp_q.push_back(e);
    end
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    track(OP_SUB, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    readback(3'd2, 32'hE100_E100, 1'b0);
    readback(3'd7, 32'h00E1_00E0, 1'b0);

    // Collision: load to rd on the EXEC edge loses to writeback
    load(3'd1, 32'd10);
    load(3'd2, 32'd3);
    issue(OP_ADD, 3'd5, 3'd1, 3'd2, 32'd13, 1'b0, 1'b1);
    @(posedge Clk); #1;
    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 32'h0000_DEAD;
    @(posedge Clk); #1;
    ld_en = 1'b0;
    readback(3'd5, 32'd13, 1'b0);

    // Collision: load to rs on the READ edge; old value used. Load to a
    // different index on the EXEC edge also lands.
    issue(OP_SUB, 3'd6, 3'd1, 3'd2, 32'd7, 1'b0, 1'b1);
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 32'd100;
    @(posedge Clk); #1;
    ld_addr = 3'd0; ld_data = 32'h55;
    @(posedge Clk); #1;
    ld_en = 1'b0;
    readback(3'd6, 32'd7, 1'b0);
    readback(3'd1, 32'd100, 1'b0);
    readback(3'd0, 32'h55, 1'b0);

    // Reset during EXEC, with a load on the reset edge
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 32'd0, 1'b0, 1'b0);
    @(posedge Clk); #1;
    Clrn = 1'b0; ld_en = 1'b1; ld_addr = 3'd7; ld_data = 32'h0000_0BAD;
    @(posedge Clk); #1;
    Clrn = 1'b1; ld_en = 1'b0;
    @(negedge Clk);
    check("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("mrst_alu_x", Alu_X, 32'd0);
    check("mrst_alu_y", Alu_Y, 32'd0);
    check("mrst_aluc", {30'd0, Alu_Aluc}, 32'd0);
    check("mrst_rsp_data", rsp_data, 32'd0);
    check("mrst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    @(negedge Clk);
    check("mrst_rel_ready", {31'd0, cmd_ready}, 32'd1);
    check("mrst_rel_valid", {31'd0, rsp_valid}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      readback(3'(r), 32'd0, 1'b1);
    end

    // Drain the scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("scoreboard_drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Multi-cycle issue controller that drives the 32-bit two-bit-opcode ALU as its initiator. It accepts register-to-register commands over a valid/ready handshake and reads two operands from a local register file. It presents them to the ALU, captures the ALU result and zero flag, writes the result back, and returns a response over a second valid/ready handshake. It sits between the instruction/command source and the combinational ALU.

## Interface
- WIDTH, 32, data width; must match the ALU.
- NREG, 8, number of registers; a power of two. AW = log2(NREG).
- Clk  in  1  sole clock; all state updates on the rising edge.
- Clrn  in  1  reset; synchronous and active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  ALU opcode: 00 add, 01 sub, 10 and, 11 or.
- cmd_rd, cmd_rs, cmd_rt  in  AW each  destination, first source and second source register indices.
- ld_en  in  1  register-file load strobe, for preload by the bench or boot.
- ld_addr  in  AW  load index.
- ld_data  in  WIDTH  load data.
- Alu_X, Alu_Y  out  WIDTH  ALU operands.
- Alu_Aluc  out  2  ALU opcode.
- Alu_R  in  WIDTH  ALU result.
- Alu_Z  in  1  ALU zero flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  WIDTH  result written to rd.
- rsp_zero  out  1  captured Alu_Z.

## Operation
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch op, rd, rs and rt, then go to READ.
  - READ: X_reg<=RF[rs], Y_reg<=RF[rt], Aluc_reg<=op, then go to EXEC.
  - EXEC: the ALU evaluates combinationally from the registered operands. On the edge: RF[rd]<=Alu_R, rsp_data<=Alu_R, rsp_zero<=Alu_Z, then go to RESP.
  - RESP: rsp_valid=1. When rsp_ready=1, go to IDLE.
- cmd_ready is asserted only in IDLE. rsp_valid is asserted only in RESP.
- rsp_data and rsp_zero stay stable throughout RESP.
- Alu_X, Alu_Y and Alu_Aluc are driven directly from registers, with no combinational path from cmd_*.
- These registers hold their value outside READ/EXEC and change only on the READ edge.
- rsp_zero is Alu_Z taken verbatim; the block does not recompute it.
- Arithmetic is entirely inside the ALU. The block performs no width extension; carry and overflow are not observed.
- Register file:
  - NREG x WIDTH, all registers writable, including index 0.
  - Reads are read-before-write: a write on the same edge as READ is not seen by that READ.
  - rs==rt is legal. rd may equal rs or rt; the result overwrites the register after the operands are captured.
- ld_en is honoured in every state.
- If ld_en and the EXEC writeback target the same index on the same edge, the writeback wins. If they target different indices, both take effect.
- An opcode is never illegal; all four values are passed through.

## Timing
- Command accepted at edge E0: READ during the next cycle, EXEC after E1, RESP after E2.
- rsp_valid is high 3 cycles after the accepting edge.
- With rsp_ready held high, RESP lasts 1 cycle and IDLE 1 cycle, giving a throughput of 1 command per 4 cycles.
- rsp_ready low: the block holds RESP indefinitely and cmd_ready stays 0. No command is dropped or queued.
- Reset with Clrn=0 at an edge:
  - state goes to IDLE, and every register-file entry goes to 0.
  - Alu_X, Alu_Y and rsp_data go to 0; Alu_Aluc goes to 00; rsp_zero and rsp_valid go to 0.
  - cmd_ready is 0 while Clrn=0 and 1 from the first cycle after release.
- Reset mid-operation aborts the command: no writeback and no response. A ld_en on a reset edge is ignored.

## Structure
- Package alu_issue_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11;
  - the state enum IDLE/READ/EXEC/RESP, encoded as 2 bits.
- Sub-module alu_regfile contains NREG x WIDTH storage with:
  - synchronous reset;
  - two asynchronous read ports;
  - one write port with priority-muxed writeback over load.
- The ALU is instantiated outside this block.
- The bench connects it through the Alu_* ports, using either the real ALU or a behavioural model with Z=(R==0).

## Test plan
- **Basic add:** preload R1=5 and R2=7, issue add rd=3 rs=1 rt=2, rsp_ready=1.
  - Expect rsp_valid 3 cycles after acceptance, with rsp_data=12 and rsp_zero=0.
  - Expect R3=12.
- **Subtract to zero:** R1=0x1234, issue sub rd=4 rs=1 rt=1.
  - Expect rsp_data=0, rsp_zero=1 and R4=0.
- **Logic ops:** R1=0xF0F0F0F0, R2=0x0FF00FF0.
  - and gives 0x00F000F0.
  - or gives 0xFFF0FFF0.
  - Alu_Aluc must equal the issued op during EXEC.
- **Backpressure:** hold rsp_ready=0 for 5 cycles while cmd_valid stays high with a second command.
  - cmd_ready stays 0 and the rsp_* outputs stay stable.
  - Release: the second command is accepted one cycle after the RESP-exit edge.
- **Collisions:** ld_en to rd on the EXEC edge leaves RF[rd]=ALU result. ld_en to rs during READ makes the old value be used.
- **Reset mid-op:** drop Clrn during EXEC.
  - No rsp_valid, and RF is all zero.
  - All outputs at their reset values, and cmd_ready=1 one cycle after release.
